// File: rtl/bcd_time_pkg.sv
// Shared definitions for the BCD time counter: FSM state encoding, BCD widths
// and the single-pair BCD step helpers used by every pair counter.
// No ports; imported with `import bcd_time_pkg::*;`.
package bcd_time_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_SET  = 2'd2
  } state_t;

  localparam int BCD_W  = 4;
  localparam int PAIR_W = 8;

  localparam logic [PAIR_W-1:0] BCD_ZERO = 8'h00;

  // One BCD step up within a pair; max wraps to 00.
  function automatic logic [PAIR_W-1:0] bcd_pair_inc(input logic [PAIR_W-1:0] v,
                                                      input logic [PAIR_W-1:0] max);
    logic [PAIR_W-1:0] r;
    if (v == max) begin
      r = BCD_ZERO;
    end else if (v[BCD_W-1:0] == 4'd9) begin
      r = {v[PAIR_W-1:BCD_W] + 4'd1, 4'd0};
    end else begin
      r = {v[PAIR_W-1:BCD_W], v[BCD_W-1:0] + 4'd1};
    end
    return r;
  endfunction

  // One BCD step down within a pair; 00 wraps to max.
  function automatic logic [PAIR_W-1:0] bcd_pair_dec(input logic [PAIR_W-1:0] v,
                                                      input logic [PAIR_W-1:0] max);
    logic [PAIR_W-1:0] r;
    if (v == BCD_ZERO) begin
      r = max;
    end else if (v[BCD_W-1:0] == 4'd0) begin
      r = {v[PAIR_W-1:BCD_W] - 4'd1, 4'd9};
    end else begin
      r = {v[PAIR_W-1:BCD_W], v[BCD_W-1:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// One two-digit BCD group of the time counter.
// Ports: clk_out/rst (async active-high), up/down step request gated by cin
// (carry/borrow in from the lower pair), inc (set-mode +1, no carry out),
// max (BCD wrap value), value (registered), value_next (value after this edge),
// cout (carry/borrow to the next pair, combinational).
module bcd_pair_counter
  import bcd_time_pkg::*;
(
  input  logic              clk_out,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              inc,
  input  logic              cin,
  input  logic [PAIR_W-1:0] max,
  output logic [PAIR_W-1:0] value,
  output logic [PAIR_W-1:0] value_next,
  output logic              cout
);

  always_comb begin
    value_next = value;
    cout       = 1'b0;
    if (inc) begin
      // Manual adjust wraps locally and never disturbs neighbouring pairs.
      value_next = bcd_pair_inc(value, max);
    end else if (up && cin) begin
      value_next = bcd_pair_inc(value, max);
      cout       = (value == max);
    end else if (down && cin) begin
      value_next = bcd_pair_dec(value, max);
      cout       = (value == BCD_ZERO);
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      value <= BCD_ZERO;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// Parametrised BCD time counter: NUM_PAIRS two-digit groups, run/stop, up/down,
// manual set mode, registered rollover/done pulses and combinational zero.
// Ports: clk_out, rst (async active-high), run, dir, set_mode, set_sel, set_inc,
// digits, rollover, done, zero, running, alarm_val, alarm.
// Optional feature: define BCD_ALARM_EN for the alarm compare; otherwise alarm=0.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int                NUM_PAIRS = 2,
  parameter logic [PAIR_W-1:0] TOP_MAX   = 8'h59,
  parameter logic [PAIR_W-1:0] LOW_MAX   = 8'h59
) (
  input  logic                        clk_out,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        dir,
  input  logic                        set_mode,
  input  logic [1:0]                  set_sel,
  input  logic                        set_inc,
  output logic [PAIR_W*NUM_PAIRS-1:0] digits,
  output logic                        rollover,
  output logic                        done,
  output logic                        zero,
  output logic                        running,
  input  logic [PAIR_W*NUM_PAIRS-1:0] alarm_val,
  output logic                        alarm
);

  localparam int DW = PAIR_W * NUM_PAIRS;
  // All-zero except pair0 units = 1; BCD and binary encodings coincide here.
  localparam logic [DW-1:0] DIG_ONE = DW'(1);

  state_t state, state_next;
  logic step_up, step_down, inc_en;
  logic last_down;
  logic [NUM_PAIRS:0] carry;
  logic [DW-1:0] digits_next;

  assign zero      = (digits == '0);
  assign running   = (state == ST_RUN);
  assign last_down = (digits == DIG_ONE);
  assign carry[0]  = 1'b1;

  for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pair
    bcd_pair_counter u_pair (
      .clk_out    (clk_out),
      .rst        (rst),
      .up         (step_up),
      .down       (step_down),
      .inc        (inc_en && (int'(set_sel) == i)),
      .cin        (carry[i]),
      .max        ((i == NUM_PAIRS - 1) ? TOP_MAX : LOW_MAX),
      .value      (digits[PAIR_W*i +: PAIR_W]),
      .value_next (digits_next[PAIR_W*i +: PAIR_W]),
      .cout       (carry[i+1])
    );
  end

  // A step is taken on every edge where run is high and set_mode is low,
  // including the edge that leaves STOP, so the first count lands on the
  // first edge after run is raised (or after reset release with run high).
  always_comb begin
    state_next = state;
    step_up    = 1'b0;
    step_down  = 1'b0;
    inc_en     = 1'b0;
    case (state)
      ST_SET: begin
        if (!set_mode) begin
          state_next = ST_STOP;
        end else begin
          inc_en = set_inc;
        end
      end
      ST_STOP, ST_RUN: begin
        if (set_mode) begin
          state_next = ST_SET;
        end else if (!run) begin
          state_next = ST_STOP;
        end else if (dir) begin
          if (zero) begin
            // Already at the bottom: no step, no done pulse.
            state_next = ST_STOP;
          end else begin
            step_down  = 1'b1;
            state_next = last_down ? ST_STOP : ST_RUN;
          end
        end else begin
          step_up    = 1'b1;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state    <= ST_STOP;
      rollover <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      // Top pair carrying out means every pair wrapped on this step.
      rollover <= step_up && carry[NUM_PAIRS];
      done     <= step_down && last_down;
    end
  end

`ifdef BCD_ALARM_EN
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      alarm <= 1'b0;
    end else begin
      alarm <= (step_up || step_down) && (digits_next == alarm_val);
    end
  end
`else
  logic alarm_unused;
  assign alarm_unused = ^{alarm_val, digits_next};
  assign alarm        = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: two instances (MM:SS and HH:MM:SS) share the
// control inputs; a mixed-radix integer model of each counter predicts outputs.
module tb_bcd_time_counter;

  logic clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  logic rst, run, dir, set_mode, set_inc;
  logic [1:0] set_sel;
  logic [15:0] dig0, alv0;
  logic [23:0] dig1, alv1;
  logic roll0, done0, zero0, run0, al0;
  logic roll1, done1, zero1, run1, al1;

  bcd_time_counter dut (
    .clk_out(clk_out), .rst(rst), .run(run), .dir(dir), .set_mode(set_mode),
    .set_sel(set_sel), .set_inc(set_inc), .digits(dig0), .rollover(roll0),
    .done(done0), .zero(zero0), .running(run0), .alarm_val(alv0), .alarm(al0)
  );

  bcd_time_counter #(.NUM_PAIRS(3), .TOP_MAX(8'h23), .LOW_MAX(8'h59)) dut_h (
    .clk_out(clk_out), .rst(rst), .run(run), .dir(dir), .set_mode(set_mode),
    .set_sel(set_sel), .set_inc(set_inc), .digits(dig1), .rollover(roll1),
    .done(done1), .zero(zero1), .running(run1), .alarm_val(alv1), .alarm(al1)
  );

  int checks = 0;
  int failures = 0;

  // Model: each counter is an integer in mixed radix (60, 60, top base).
  localparam int M_STOP = 0, M_RUN = 1, M_SET = 2;
  int np   [2] = '{2, 3};
  int topb [2] = '{60, 24};
  int cnt  [2];
  int ms   [2];
  bit roll_m [2], done_m [2], al_m [2];

  function automatic int base(int k, int p);
    return (p == np[k] - 1) ? topb[k] : 60;
  endfunction

  function automatic int weight(int k, int p);
    int w = 1;
    for (int i = 0; i < p; i++) w = w * base(k, i);
    return w;
  endfunction

  function automatic logic [23:0] bcd(int k);
    logic [23:0] r = '0;
    for (int p = 0; p < np[k]; p++) begin
      int v;
      v = (cnt[k] / weight(k, p)) % base(k, p);
      r[8*p +: 8] = 8'((v / 10) * 16 + (v % 10));
    end
    return r;
  endfunction

  function automatic logic [23:0] alv(int k);
    return (k == 0) ? {8'h00, alv0} : alv1;
  endfunction

  function automatic logic [28:0] expv(int k);
    return {bcd(k), roll_m[k], done_m[k], cnt[k] == 0, ms[k] == M_RUN, al_m[k]};
  endfunction

  function automatic logic [28:0] actv(int k);
    if (k == 0) return {8'h00, dig0, roll0, done0, zero0, run0, al0};
    return {dig1, roll1, done1, zero1, run1, al1};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; ms[k] = M_STOP; roll_m[k] = 0; done_m[k] = 0; al_m[k] = 0;
    end
  endtask

  task automatic model_edge(int k);
    int p, v, w;
    roll_m[k] = 0; done_m[k] = 0; al_m[k] = 0;
    if (ms[k] == M_SET) begin
      if (!set_mode) ms[k] = M_STOP;
      else if (set_inc && int'(set_sel) < np[k]) begin
        p = int'(set_sel);
        w = weight(k, p);
        v = (cnt[k] / w) % base(k, p);
        cnt[k] = cnt[k] - v * w + ((v + 1) % base(k, p)) * w;
      end
    end else if (set_mode) begin
      ms[k] = M_SET;
    end else if (!run) begin
      ms[k] = M_STOP;
    end else if (dir) begin
      if (cnt[k] == 0) ms[k] = M_STOP;
      else begin
        cnt[k] = cnt[k] - 1;
        if (cnt[k] == 0) begin done_m[k] = 1; ms[k] = M_STOP; end
        else ms[k] = M_RUN;
`ifdef BCD_ALARM_EN
        al_m[k] = (bcd(k) == alv(k));
`endif
      end
    end else begin
      cnt[k] = (cnt[k] + 1) % weight(k, np[k]);
      roll_m[k] = (cnt[k] == 0);
      ms[k] = M_RUN;
`ifdef BCD_ALARM_EN
      al_m[k] = (bcd(k) == alv(k));
`endif
    end
  endtask

  // Inputs change at posedge+1; the model advances with the edge.
  task automatic tick();
    @(posedge clk_out);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 0; dir = 0; set_mode = 0; set_sel = 0; set_inc = 0;
    alv0 = 16'h9999; alv1 = 24'h999999;
    model_reset();
    repeat (2) @(posedge clk_out);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (actv(k) !== 29'b00100) begin
        failures++;
        $display("FAIL reset inst%0d got %h want %h", k, actv(k), 29'b00100);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_up_count();
    run = 1; dir = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (actv(k) !== expv(k)) begin
          failures++;
          $display("FAIL up_count inst%0d edge%0d got %h want %h", k, e, actv(k), expv(k));
        end
      end
    end
    checks++;
    if (dig0 !== 16'h0100 || dig1 !== 24'h000100) begin
      failures++;
      $display("FAIL up_60 got %h/%h want 0100/000100", dig0, dig1);
    end
  endtask

  task automatic test_down_count();
    dir = 1;
    tick();
    checks++;
    if (dig0 !== 16'h0059 || dig1 !== 24'h000059) begin
      failures++;
      $display("FAIL down_first got %h/%h want 0059/000059", dig0, dig1);
    end
    for (int e = 0; e < 59; e++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (actv(k) !== expv(k)) begin
          failures++;
          $display("FAIL down_count inst%0d edge%0d got %h want %h", k, e, actv(k), expv(k));
        end
      end
    end
    checks++;
    if (dig0 !== 16'h0000 || done0 !== 1'b1 || run0 !== 1'b0 || done1 !== 1'b1) begin
      failures++;
      $display("FAIL down_done got dig=%h done=%b/%b running=%b want 0000 1/1 0",
               dig0, done0, done1, run0);
    end
    tick();
    checks++;
    if (dig0 !== 16'h0000 || done0 !== 1'b0 || run0 !== 1'b0 || zero0 !== 1'b1) begin
      failures++;
      $display("FAIL down_hold got dig=%h done=%b running=%b zero=%b want 0000 0 0 1",
               dig0, done0, run0, zero0);
    end
  endtask

  task automatic test_set_mode();
    apply_reset();
    run = 0; dir = 0; set_mode = 1;
    tick();
    set_sel = 2'd1; set_inc = 1;
    for (int e = 0; e < 61; e++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (actv(k) !== expv(k)) begin
          failures++;
          $display("FAIL set_inc inst%0d edge%0d got %h want %h", k, e, actv(k), expv(k));
        end
      end
    end
    checks++;
    if (dig0 !== 16'h0100 || dig1 !== 24'h000100) begin
      failures++;
      $display("FAIL set_61 got %h/%h want 0100/000100", dig0, dig1);
    end
    set_mode = 0; set_inc = 0;
    tick();
    checks++;
    if (dig0 !== 16'h0100 || run0 !== 1'b0 || actv(1) !== expv(1)) begin
      failures++;
      $display("FAIL set_release got dig=%h running=%b want 0100 0", dig0, run0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    run = 0; dir = 0; set_mode = 1;
    tick();
    set_inc = 1;
    set_sel = 2'd2; repeat (23) tick();
    set_sel = 2'd1; repeat (59) tick();
    set_sel = 2'd0; repeat (59) tick();
    checks++;
    if (dig0 !== 16'h5959 || dig1 !== 24'h235959) begin
      failures++;
      $display("FAIL preset got %h/%h want 5959/235959", dig0, dig1);
    end
    set_mode = 0; set_inc = 0; set_sel = 0;
    tick();
    run = 1;
    tick();
    checks++;
    if (dig0 !== 16'h0000 || dig1 !== 24'h000000 || roll0 !== 1'b1 || roll1 !== 1'b1) begin
      failures++;
      $display("FAIL wrap got %h/%h roll=%b/%b want 0000/000000 1/1", dig0, dig1, roll0, roll1);
    end
    tick();
    checks++;
    if (dig0 !== 16'h0001 || roll0 !== 1'b0 || roll1 !== 1'b0 || run0 !== 1'b1) begin
      failures++;
      $display("FAIL after_wrap got %h roll=%b/%b running=%b want 0001 0/0 1",
               dig0, roll0, roll1, run0);
    end
  endtask

  task automatic test_run_hold();
    apply_reset();
    run = 1; dir = 0;
    for (int e = 0; e < 754; e++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (actv(k) !== expv(k)) begin
          failures++;
          $display("FAIL run_to_1234 inst%0d edge%0d got %h want %h", k, e, actv(k), expv(k));
        end
      end
    end
    run = 0;
    repeat (3) tick();
    checks++;
    if (dig0 !== 16'h1234 || dig1 !== 24'h001234 || run0 !== 1'b0) begin
      failures++;
      $display("FAIL hold got %h/%h running=%b want 1234/001234 0", dig0, dig1, run0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dig0 !== 16'h0000 || dig1 !== 24'h000000 || zero0 !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got %h/%h zero=%b want 0000/000000 1", dig0, dig1, zero0);
    end
    rst = 1'b0;
    model_reset();
    run = 1;
    tick();
    checks++;
    if (dig0 !== 16'h0001 || run0 !== 1'b1) begin
      failures++;
      $display("FAIL first_step got %h running=%b want 0001 1", dig0, run0);
    end
  endtask

  task automatic test_alarm();
    logic want;
    apply_reset();
    alv0 = 16'h0005; alv1 = 24'h000005;
    run = 1; dir = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
`ifdef BCD_ALARM_EN
      want = (e == 5);
`else
      want = 1'b0;
`endif
      checks++;
      if (al0 !== want || al1 !== want) begin
        failures++;
        $display("FAIL alarm edge%0d got %b/%b want %b", e, al0, al1, want);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    alv0 = 16'h0010; alv1 = 24'h000003;
    set_mode = 0; set_inc = 0; dir = 0;
    for (int e = 0; e < 2000; e++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 47) == 0) set_mode = ~set_mode;
      set_sel = 2'($urandom_range(0, 3));
      set_inc = 1'($urandom_range(0, 1));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (actv(k) !== expv(k)) begin
          failures++;
          $display("FAIL random inst%0d edge%0d got %h want %h", k, e, actv(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_set_mode();
    test_wrap();
    test_run_hold();
    test_alarm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
